// File: rtl/mult_arb_pkg.sv
// Shared definitions for the mult32x32 requester arbiter.
//   OP_W        : operand width presented to the multiplier
//   PROD_W      : product width returned by the multiplier
//   MAX_NUM_REQ : largest supported requester count
//   IDX_W       : width of a requester index, sized for MAX_NUM_REQ
//   arb_state_t : arbiter FSM states
package mult_arb_pkg;

    localparam int unsigned OP_W        = 32;
    localparam int unsigned PROD_W      = 64;
    localparam int unsigned MAX_NUM_REQ = 8;
    localparam int unsigned IDX_W       = $clog2(MAX_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/mult32x32_arbiter_rr.sv
// Combinational round-robin picker.
//   req       : request vector, one bit per requester
//   ptr       : index of the most recently served requester
//   grant     : one-hot winner (all zero when nothing requests)
//   grant_idx : binary index of the winner
//   any_grant : high when some requester won
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    int unsigned p;

    // Search runs in two passes so the scan starts just after ptr and
    // wraps around: first the indices above ptr, then 0..ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        p         = 32'(ptr);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_grant && (i > p) && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                any_grant = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_grant && (i <= p) && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult32x32_arbiter.sv
// Round-robin front-end sharing one mult32x32 multiplier among NUM_REQ
// requesters. Accepts an operand pair from the winner, issues a start
// pulse, waits for the multiplier to drop busy, captures the product and
// returns it to the originating requester with a valid/ready handshake.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_a/req_b : per-requester operand offers
//   req_ready             : one-hot accept pulse
//   rsp_valid/rsp_product : one-hot response valid, shared product
//   rsp_ready             : per-requester response consume
//   mult_start/mult_a/b   : multiplier command and held operands
//   mult_busy/mult_product: multiplier status and result
//   arb_busy              : arbiter not IDLE
//   ops_done              : completed-operation counter (wraps)
module mult32x32_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][OP_W-1:0]  req_a,
    input  logic [NUM_REQ-1:0][OP_W-1:0]  req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [PROD_W-1:0]             rsp_product,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic                          mult_start,
    output logic [OP_W-1:0]               mult_a,
    output logic [OP_W-1:0]               mult_b,
    input  logic                          mult_busy,
    input  logic [PROD_W-1:0]             mult_product,
    output logic                          arb_busy,
    output logic [CNT_W-1:0]              ops_done
);

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [NUM_REQ-1:0]   owner;
    logic [IDX_W-1:0]     owner_idx;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 any_grant;
    logic [OP_W-1:0]      sel_a, sel_b;
    logic                 take, capture, release_op, resp_ack;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // One-hot operand mux avoids indexing the packed arrays with a
    // pointer whose width is sized for the maximum requester count.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i];
                sel_b = req_b[i];
            end
        end
    end

    // Only the owner's rsp_ready counts; other requesters are ignored.
    assign resp_ack  = |(rsp_ready & owner);
    assign rsp_valid = (state == RESP) ? owner : '0;
    assign arb_busy  = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        take       = 1'b0;
        capture    = 1'b0;
        release_op = 1'b0;
        mult_start = 1'b0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (any_grant && !mult_busy) begin
                    take      = 1'b1;
                    // Gated by reset so req_ready reads 0 while held in reset.
                    req_ready = reset_n ? grant : '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mult_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (!mult_busy) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ack) begin
                    release_op = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            // Pointer starts at the last index so requester 0 wins first.
            ptr         <= IDX_W'(NUM_REQ - 1);
            owner       <= '0;
            owner_idx   <= '0;
            mult_a      <= '0;
            mult_b      <= '0;
            rsp_product <= '0;
            ops_done    <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner     <= grant;
                owner_idx <= grant_idx;
                mult_a    <= sel_a;
                mult_b    <= sel_b;
            end
            if (capture) begin
                rsp_product <= mult_product;
                ops_done    <= ops_done + CNT_W'(1);
            end
            // Pointer advances only once the response is consumed.
            if (release_op) begin
                ptr <= owner_idx;
            end
        end
    end

endmodule

// File: tb/tb_mult32x32_arbiter.sv
module tb_mult32x32_arbiter;

    localparam int N = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [N-1:0]          req_valid;
    logic [N-1:0][31:0]    req_a;
    logic [N-1:0][31:0]    req_b;
    logic [N-1:0]          req_ready;
    logic [N-1:0]          rsp_valid;
    logic [63:0]           rsp_product;
    logic [N-1:0]          rsp_ready;
    logic                  mult_start;
    logic [31:0]           mult_a;
    logic [31:0]           mult_b;
    logic                  mult_busy;
    logic [63:0]           mult_product;
    logic                  arb_busy;
    logic [15:0]           ops_done;
    logic                  force_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult32x32_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_product  (rsp_product),
        .rsp_ready    (rsp_ready),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_product (mult_product),
        .arb_busy     (arb_busy),
        .ops_done     (ops_done)
    );

    // Multiplier stand-in: busy with start and for four steps after it,
    // product formed from the operands present on the last step.
    logic [2:0]  m_cnt;
    logic [63:0] m_prod;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt  <= '0;
            m_prod <= '0;
        end else if (mult_start) begin
            m_cnt <= 3'd4;
        end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
            if (m_cnt == 3'd1) m_prod <= {32'd0, mult_a} * {32'd0, mult_b};
        end
    end
    assign mult_busy    = mult_start | (m_cnt != 3'd0) | force_busy;
    assign mult_product = m_prod;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Transaction-level reference: at most one operation in flight.
    bit          m_active;
    bit          m_capt;
    int          m_idx;
    int          m_t;
    int          m_last;
    logic [31:0] m_ma, m_mb;
    logic [63:0] m_pexp;
    logic [15:0] m_done;

    task automatic model_reset();
        m_active = 0;
        m_capt   = 0;
        m_idx    = 0;
        m_t      = 0;
        m_last   = N - 1;
        m_ma     = '0;
        m_mb     = '0;
        m_pexp   = '0;
        m_done   = '0;
    endtask

    always @(negedge clk) begin
        int w;
        logic [N-1:0] exp_rr;
        if (!reset_n) begin
            model_reset();
            check("rst_req_ready", req_ready, '0);
            check("rst_rsp_valid", rsp_valid, '0);
            check("rst_mult_start", mult_start, 0);
            check("rst_arb_busy", arb_busy, 0);
            check("rst_ops_done", ops_done, 0);
        end else begin
            w = -1;
            exp_rr = '0;
            if (!m_active && (|req_valid) && !mult_busy) begin
                w = rr_pick(req_valid, m_last);
                exp_rr = oh(w);
            end
            check("req_ready", req_ready, exp_rr);
            check("arb_busy", arb_busy, m_active);
            check("mult_start", mult_start, m_active && (cyc == m_t + 1));
            check("rsp_valid", rsp_valid, (m_active && m_capt) ? oh(m_idx) : '0);
            check("rsp_product", rsp_product, m_pexp);
            check("ops_done", ops_done, m_done);
            check("mult_a", mult_a, m_ma);
            check("mult_b", mult_b, m_mb);
            if (w >= 0) begin
                m_active = 1;
                m_capt   = 0;
                m_idx    = w;
                m_ma     = req_a[w];
                m_mb     = req_b[w];
                m_t      = cyc;
            end else if (m_active && !m_capt && (cyc >= m_t + 2) && !mult_busy) begin
                m_capt = 1;
                m_pexp = {32'd0, m_ma} * {32'd0, m_mb};
                m_done = m_done + 16'd1;
            end else if (m_active && m_capt && rsp_ready[m_idx]) begin
                m_active = 0;
                m_last   = m_idx;
            end
        end
    end

    task automatic drive_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int idx, input int budget, output int t);
        t = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                t = cyc;
                return;
            end
        end
        timeout("wait_req_ready");
    endtask

    task automatic wait_rsp(input int idx, input int budget, output int t);
        t = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (rsp_valid[idx]) begin
                t = cyc;
                return;
            end
        end
        timeout("wait_rsp_valid");
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!arb_busy) return;
        end
        timeout("wait_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;
        logic [15:0] d0;
        int exp_order [4] = '{0, 1, 0, 1};
        logic [63:0] exp_prod [2] = '{64'h0000_0000_0001_0000, 64'h0000_0000_FF00_0000};

        reset_n    = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = '0;
        force_busy = 1'b0;
        model_reset();
        repeat (3) drive_tick();
        reset_n = 1'b1;

        // Single request, latency pinned by literals.
        drive_tick();
        req_valid = 2'b01;
        req_a[0]  = 32'h0001_0002;
        req_b[0]  = 32'h0003_0004;
        rsp_ready = 2'b01;
        wait_ready(0, 20, t0);
        check("t1_ready", req_ready, 2'b01);
        drive_tick();
        req_valid = '0;
        @(negedge clk);
        check("t1_start", mult_start, 1);
        wait_rsp(0, 20, t1);
        check("t1_latency", t1 - t0, 7);
        check("t1_product", rsp_product, 64'h0000_0003_000A_0008);
        check("t1_ops_done", ops_done, 1);
        wait_idle(10);

        // Max operands on requester 1.
        drive_tick();
        req_valid = 2'b10;
        req_a[1]  = 32'hFFFF_FFFF;
        req_b[1]  = 32'hFFFF_FFFF;
        rsp_ready = 2'b11;
        wait_ready(1, 20, t0);
        drive_tick();
        req_valid = '0;
        wait_rsp(1, 20, t1);
        check("t2_rsp_valid", rsp_valid, 2'b10);
        check("t2_product", rsp_product, 64'hFFFF_FFFE_0000_0001);
        wait_idle(10);

        // Contention: grants alternate 0,1,0,1.
        d0 = ops_done;
        drive_tick();
        req_a[0]  = 32'h0000_1000;
        req_b[0]  = 32'h0000_0010;
        req_a[1]  = 32'h00FF_0000;
        req_b[1]  = 32'h0000_0100;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_ready(exp_order[n], 20, t0);
            check("t3_grant", req_ready, oh(exp_order[n]));
            if (n == 3) begin
                drive_tick();
                req_valid = '0;
            end
            wait_rsp(exp_order[n], 20, t1);
            check("t3_product", rsp_product, exp_prod[exp_order[n]]);
        end
        wait_idle(10);
        check("t3_ops_delta", 16'(ops_done - d0), 4);

        // Backpressure on requester 0 blocks requester 1.
        drive_tick();
        req_a[0]  = 32'd3;
        req_b[0]  = 32'd5;
        req_a[1]  = 32'd7;
        req_b[1]  = 32'd9;
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        wait_ready(0, 20, t0);
        wait_rsp(0, 20, t1);
        check("t4_product0", rsp_product, 64'd15);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t4_hold_valid", rsp_valid, 2'b01);
            check("t4_hold_product", rsp_product, 64'd15);
            check("t4_no_grant", req_ready, 2'b00);
        end
        drive_tick();
        rsp_ready = 2'b01;
        @(negedge clk);
        check("t4_handshake_valid", rsp_valid, 2'b01);
        drive_tick();
        rsp_ready = 2'b11;
        @(negedge clk);
        check("t4_grant1_next", req_ready, 2'b10);
        drive_tick();
        req_valid = '0;
        wait_rsp(1, 20, t1);
        check("t4_product1", rsp_product, 64'd63);
        wait_idle(10);

        // Operands stay latched when the requester changes its inputs.
        drive_tick();
        req_valid = 2'b01;
        req_a[0]  = 32'h0000_FFFF;
        req_b[0]  = 32'h0001_0000;
        wait_ready(0, 20, t0);
        drive_tick();
        req_valid = '0;
        req_a[0]  = 32'hDEAD_BEEF;
        req_b[0]  = 32'h1234_5678;
        t1 = -1;
        for (int k = 0; k < 20 && t1 < 0; k++) begin
            @(negedge clk);
            check("t5_mult_a", mult_a, 32'h0000_FFFF);
            check("t5_mult_b", mult_b, 32'h0001_0000);
            if (rsp_valid[0]) t1 = cyc;
        end
        if (t1 < 0) timeout("t5_rsp");
        check("t5_product", rsp_product, 64'h0000_0000_FFFF_0000);
        wait_idle(10);

        // No grant while the multiplier reports busy in IDLE.
        drive_tick();
        force_busy = 1'b1;
        req_valid  = 2'b01;
        req_a[0]   = 32'd11;
        req_b[0]   = 32'd13;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t6_guard", req_ready, 2'b00);
        end
        drive_tick();
        force_busy = 1'b0;
        wait_ready(0, 5, t0);
        drive_tick();
        req_valid = '0;
        wait_rsp(0, 20, t1);
        check("t6_product", rsp_product, 64'd143);
        wait_idle(10);

        // Reset in the middle of an operation.
        drive_tick();
        req_valid = 2'b10;
        req_a[1]  = 32'd2;
        req_b[1]  = 32'd3;
        wait_ready(1, 20, t0);
        drive_tick();
        req_valid = '0;
        drive_tick();
        drive_tick();
        reset_n = 1'b0;
        #1;
        check("t7_async_rsp_valid", rsp_valid, '0);
        check("t7_async_arb_busy", arb_busy, 0);
        check("t7_async_mult_a", mult_a, 0);
        check("t7_async_mult_b", mult_b, 0);
        check("t7_async_product", rsp_product, 0);
        check("t7_async_ops_done", ops_done, 0);
        check("t7_async_start", mult_start, 0);
        repeat (2) drive_tick();
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("t7_no_rsp", rsp_valid, '0);
        end
        drive_tick();
        req_valid = 2'b01;
        req_a[0]  = 32'h100;
        req_b[0]  = 32'h100;
        wait_ready(0, 20, t0);
        drive_tick();
        req_valid = '0;
        wait_rsp(0, 20, t1);
        check("t7_ops_done", ops_done, 1);
        check("t7_product", rsp_product, 64'h1_0000);
        wait_idle(10);

        // Random traffic against the reference.
        for (int k = 0; k < 500; k++) begin
            drive_tick();
            req_valid  = N'($urandom);
            rsp_ready  = N'($urandom);
            force_busy = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_a[i] = $urandom;
                    req_b[i] = $urandom;
                end
            end
        end
        drive_tick();
        req_valid  = '0;
        rsp_ready  = '1;
        force_busy = 1'b0;
        wait_idle(50);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult32x32_arbiter.md
Name: mult32x32_arbiter

Overview:
Round-robin front-end that shares one mult32x32 multiplier between NUM_REQ requesters. It accepts a 32x32 operand pair from the winning requester and latches it. It issues a start pulse, holds the operands stable while the multiplier sequences its 16x16 partial products, and captures the 64-bit product when the multiplier drops busy. It then returns the product to the originating requester with a valid/ready handshake.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has operands
req_a  in  NUM_REQ x 32  operand A per requester (unsigned)
req_b  in  NUM_REQ x 32  operand B per requester (unsigned)
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  NUM_REQ  one-hot, product valid for requester i
rsp_product  out  64  product, shared by all requesters
rsp_ready  in  NUM_REQ  requester i consumes product
mult_start  out  1  start pulse to multiplier
mult_a  out  32  operand A to multiplier
mult_b  out  32  operand B to multiplier
mult_busy  in  1  multiplier busy
mult_product  in  64  multiplier product register
arb_busy  out  1  high in any state except IDLE
ops_done  out  CNT_W  completed-operation count

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous and active-low.
- Reset values: FSM enters IDLE. All outputs are 0: req_ready, rsp_valid, rsp_product, mult_start, mult_a, mult_b, ops_done. The round-robin pointer resets to requester NUM_REQ-1, so requester 0 has highest priority first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high and mult_busy=0, the arbiter picks winner g round-robin, starting after the last granted index.
  - req_ready[g]=1 for exactly this cycle. req_a[g] and req_b[g] are latched into the operand registers, g is stored, and the FSM goes to ISSUE.
  - req_ready is combinational from req_valid and state.
  - If mult_busy=1 in IDLE, no grant is made (guard).
- ISSUE: mult_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - mult_start=0. mult_a and mult_b stay driven from the latches, stable for the whole operation.
  - When mult_busy=0, the arbiter captures mult_product into rsp_product, increments ops_done, and goes to RESP.
  - mult_busy is checked only from the cycle after ISSUE onward.
- RESP:
  - rsp_valid[g]=1; rsp_product is held.
  - When rsp_ready[g]=1, the arbiter updates the pointer to g and returns to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
  - No new grant is made in the same cycle as the RESP handshake.
- mult_a and mult_b are registered and change only on a grant.
- Latency with the current 4-step multiplier:
  - Accept cycle T: req_ready.
  - T+1: mult_start.
  - mult_busy is high T+1..T+5 and seen low at T+6, when the product is captured.
  - rsp_valid is first high at T+7.
- Pointer rule: the pointer updates only on response completion, so a requester stalling on rsp_ready blocks the arbiter (intended).
- Fairness: with all req_valid held high, grants rotate 0,1,...,NUM_REQ-1,0.
- ops_done wraps from all-ones to 0 with no saturation.
- Simultaneous events: a req_valid drop during ISSUE, WAIT or RESP has no effect, because the operands are already latched.
- Reset mid-operation: the arbiter returns to IDLE immediately, the in-flight result is discarded, and no rsp_valid is emitted. The multiplier reset is driven from the same source (inverted).

Decomposition:
- Package mult_arb_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP)
  - OP_W=32
  - PROD_W=64
  - max NUM_REQ constant
- Sub-module rr_arbiter: a combinational round-robin picker with inputs req vector and pointer, and outputs one-hot grant, grant index and any_grant.
- The FSM, latches and counter live in mult32x32_arbiter.

Test Plan:
- Single request: requester 0 sends a=0x0001_0002, b=0x0003_0004. Expect req_ready[0] at T, mult_start at T+1, and rsp_valid[0] at T+7 with rsp_product=0x0000_0003_000A_0008; ops_done=1.
- Max operands: a=b=0xFFFF_FFFF on requester 1. Expect rsp_product=0xFFFF_FFFE_0000_0001 on rsp_valid[1] only.
- Contention: both req_valid held high with distinct operands and rsp_ready tied high. Expect grants in the order 0,1,0,1, each product returned to the correct index, and ops_done=4.
- Backpressure: rsp_ready[0] held low for 10 cycles after rsp_valid[0]. Expect rsp_valid and rsp_product stable, requester 1 not granted meanwhile, and its grant on the cycle after the rsp_ready[0] handshake plus one IDLE cycle.
- Operand stability: requester drops req_valid and changes req_a at T+1. Expect mult_a/mult_b unchanged through WAIT and the correct original product.
- Reset mid-op: assert reset_n=0 at T+3. Expect all outputs 0 asynchronously, no rsp_valid afterwards, and a fresh request after release handled normally with ops_done starting from 0.
